blob_cfg_ctrl: RTL and testbench
================================

# blob_cfg_ctrl

Double-buffered configuration controller for the sprite (blob) engine. A host writes per-blob settings and the background colour into shadow registers through a req/ack handshake. On request, the shadow set is committed atomically to the active registers at the next vertical-blank start, so no frame shows a half-updated configuration. The active registers drive the sprite_enable/position/ram_address/layer/background inputs of the gpu top level.

## Interface
- NR_OF_BLOBS, 4, number of blobs.
- ram_add_width, 8, sprite RAM address width (≤16).
- IDX_W, $clog2(NR_OF_BLOBS) (min 1), blob index width.
- clk  in  1  system clock (single clock domain).
- reset  in  1  asynchronous, active-high reset.
- cfg_req  in  1  write request, level; held until cfg_ack.
- cfg_blob  in  IDX_W  target blob index.
- cfg_field  in  3  field select: 0 enable, 1 x1, 2 y1, 3 x2, 4 y2, 5 ram_address, 6 layer, 7 background.
- cfg_data  in  16  write data, LSB-aligned; excess bits ignored.
- cfg_ack  out  1  one-cycle pulse: write consumed.
- cfg_err  out  1  one-cycle pulse with cfg_ack: index ≥ NR_OF_BLOBS, write dropped.
- commit  in  1  pulse: arm a shadow→active transfer.
- vblank  in  1  vertical blank level (from sync_mod timing).
- pending  out  1  high while a commit is armed.
- commit_done  out  1  one-cycle pulse after the active registers load.
- sprite_enable  out  1 × NR_OF_BLOBS  active enable.
- x1_pos, y1_pos, x2_pos, y2_pos  out  10 × NR_OF_BLOBS  active coordinates.
- ram_address  out  ram_add_width × NR_OF_BLOBS  active RAM start address.
- layer  out  2 × NR_OF_BLOBS  active layer.
- background  out  12  active background colour.

## Operation
- States: IDLE, ACK, ARMED, ARMED_ACK.
- IDLE:
  - cfg_req=1 → write the shadow field and go to ACK.
  - commit=1 → go to ARMED (or ARMED_ACK if a write happens in the same cycle). The write lands before the commit takes effect.
- ACK: cfg_ack=1. cfg_req is not sampled in this cycle. Next state is IDLE (ARMED if commit=1 this cycle).
- ARMED:
  - cfg_req is stalled; no ack is given until after the commit.
  - vblank_edge → load every active register from its shadow, go to IDLE, and pulse commit_done next cycle.
  - vblank_edge is vblank & ~vblank_q, where vblank_q is vblank registered.
- ARMED_ACK: cfg_ack=1, then go to ARMED. A vblank_edge in this cycle is honoured exactly as in ARMED.
- Field widths and write rules:
  - enable takes cfg_data[0].
  - Positions take cfg_data[9:0].
  - ram_address takes cfg_data[ram_add_width-1:0].
  - layer takes cfg_data[1:0].
  - background takes cfg_data[11:0]; cfg_blob is ignored for this field.
  - Shadow writes only modify the selected field.
- Invalid index (cfg_blob ≥ NR_OF_BLOBS, field ≠ 7): the handshake completes normally with cfg_ack and cfg_err, and no register changes.
- Commit rules:
  - commit while pending=1 is ignored.
  - A commit with no intervening writes still reloads the active registers (idempotent).
  - commit in the same cycle as vblank_edge does not catch that edge; it waits for the next one.
  - A vblank_edge while not armed does nothing.
- Reset (any time, including mid-ARMED):
  - All shadow and active registers go to 0.
  - State goes to IDLE; cfg_ack, cfg_err, pending and commit_done go to 0.
  - vblank_q goes to 0, so vblank already high at reset release counts as an edge.

## Timing
- Write: cfg_req sampled high at edge N → shadow updated at N, cfg_ack high during cycle N+1.
- Throughput: earliest next write acceptance is edge N+2, i.e. 1 write per 2 cycles.
- Commit arm: commit sampled at edge C → pending high from C+1.
- Commit transfer: vblank first high in cycle E (armed) → active outputs change at edge E.
  - pending falls at edge E.
  - commit_done is high during cycle E+1.
- Active outputs change only at a commit edge or at reset; otherwise they are held.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert reset mid-cycle → all outputs 0 immediately; after release, pending=0 and background=12'h000.
- Write then commit:
  - Write blob 2 x1=10'd320, then pulse commit; vblank rises 100 cycles later.
  - Required: x1_pos[2] stays 0 until the vblank edge, then reads 320; commit_done pulses once; pending covers the window exactly.
- Stall while armed:
  - After commit, assert cfg_req (field 7, data 12'hF00).
  - Required: no cfg_ack until 2 cycles after the vblank edge; background stays at its old value, and shadow reads 12'hF00 after the next commit.
- Invalid index: NR_OF_BLOBS=3, cfg_blob=3, field 1.
  - Required: cfg_ack and cfg_err pulse together; after commit, all x1_pos are unchanged.
- Simultaneous events:
  - commit coincides with the vblank rising cycle → no transfer until the following vblank edge.
  - cfg_req and commit in the same IDLE cycle → the written value appears after the next edge.
- Reset while armed: arm, assert reset before vblank → pending=0, outputs 0, no commit_done at the subsequent vblank edge.

Source files
------------

// File: rtl/blob_cfg_ctrl.sv
// rtl/blob_cfg_ctrl.sv - double-buffered blob/background configuration with vblank-aligned commit
// Host writes land in shadow registers; an armed commit copies them to the active set on a vblank rising edge.
module blob_cfg_ctrl #(
   parameter int NR_OF_BLOBS   = 4,
   parameter int ram_add_width = 8,
   parameter int IDX_W         = (NR_OF_BLOBS > 1) ? $clog2(NR_OF_BLOBS) : 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        cfg_req,
   input  logic [IDX_W-1:0]                            cfg_blob,
   input  logic [2:0]                                  cfg_field,
   input  logic [15:0]                                 cfg_data,
   output logic                                        cfg_ack,
   output logic                                        cfg_err,
   input  logic                                        commit,
   input  logic                                        vblank,
   output logic                                        pending,
   output logic                                        commit_done,
   output logic [NR_OF_BLOBS-1:0]                      sprite_enable,
   output logic [NR_OF_BLOBS-1:0][9:0]                 x1_pos,
   output logic [NR_OF_BLOBS-1:0][9:0]                 y1_pos,
   output logic [NR_OF_BLOBS-1:0][9:0]                 x2_pos,
   output logic [NR_OF_BLOBS-1:0][9:0]                 y2_pos,
   output logic [NR_OF_BLOBS-1:0][ram_add_width-1:0]   ram_address,
   output logic [NR_OF_BLOBS-1:0][1:0]                 layer,
   output logic [11:0]                                 background
);

   typedef enum logic [1:0] {IDLE, ACK, ARMED, ARMED_ACK} state_t;

   state_t state, next_state;
   logic   vblank_q;
   logic   vblank_edge;
   logic   wr;
   logic   load;
   logic   idx_valid;
   logic   unused_data;

   logic [NR_OF_BLOBS-1:0]                    sh_en;
   logic [NR_OF_BLOBS-1:0][9:0]               sh_x1, sh_y1, sh_x2, sh_y2;
   logic [NR_OF_BLOBS-1:0][ram_add_width-1:0] sh_ram;
   logic [NR_OF_BLOBS-1:0][1:0]               sh_layer;
   logic [11:0]                               sh_bg;

   assign vblank_edge = vblank & ~vblank_q;
   assign unused_data = ^cfg_data[15:12];
   // Background is global, so its writes are valid regardless of the blob index.
   assign idx_valid   = (cfg_field == 3'd7) || (32'(cfg_blob) < 32'(NR_OF_BLOBS));

   always_comb begin
      next_state = state;
      wr         = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            wr = cfg_req;
            if (commit)
               next_state = cfg_req ? ARMED_ACK : ARMED;
            else if (cfg_req)
               next_state = ACK;
         end
         ACK: begin
            next_state = commit ? ARMED : IDLE;
         end
         ARMED: begin
            if (vblank_edge) begin
               load       = 1'b1;
               next_state = IDLE;
            end
         end
         ARMED_ACK: begin
            if (vblank_edge) begin
               load       = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = ARMED;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         vblank_q    <= 1'b0;
         cfg_ack     <= 1'b0;
         cfg_err     <= 1'b0;
         pending     <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         state       <= next_state;
         vblank_q    <= vblank;
         cfg_ack     <= (next_state == ACK) || (next_state == ARMED_ACK);
         cfg_err     <= wr & ~idx_valid;
         pending     <= (next_state == ARMED) || (next_state == ARMED_ACK);
         commit_done <= load;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_en    <= '0;
         sh_x1    <= '0;
         sh_y1    <= '0;
         sh_x2    <= '0;
         sh_y2    <= '0;
         sh_ram   <= '0;
         sh_layer <= '0;
         sh_bg    <= '0;
      end else if (wr && idx_valid) begin
         case (cfg_field)
            3'd0:    sh_en[cfg_blob]    <= cfg_data[0];
            3'd1:    sh_x1[cfg_blob]    <= cfg_data[9:0];
            3'd2:    sh_y1[cfg_blob]    <= cfg_data[9:0];
            3'd3:    sh_x2[cfg_blob]    <= cfg_data[9:0];
            3'd4:    sh_y2[cfg_blob]    <= cfg_data[9:0];
            3'd5:    sh_ram[cfg_blob]   <= cfg_data[ram_add_width-1:0];
            3'd6:    sh_layer[cfg_blob] <= cfg_data[1:0];
            default: sh_bg              <= cfg_data[11:0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sprite_enable <= '0;
         x1_pos        <= '0;
         y1_pos        <= '0;
         x2_pos        <= '0;
         y2_pos        <= '0;
         ram_address   <= '0;
         layer         <= '0;
         background    <= '0;
      end else if (load) begin
         sprite_enable <= sh_en;
         x1_pos        <= sh_x1;
         y1_pos        <= sh_y1;
         x2_pos        <= sh_x2;
         y2_pos        <= sh_y2;
         ram_address   <= sh_ram;
         layer         <= sh_layer;
         background    <= sh_bg;
      end
   end

endmodule

// File: tb/tb_blob_cfg_ctrl.sv
// tb/tb_blob_cfg_ctrl.sv - self-checking bench for blob_cfg_ctrl
// Directed and randomized host traffic compared against a shadow/active array model.
module tb_blob_cfg_ctrl;
   localparam int NB = 3;
   localparam int RW = 8;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cfg_req = 1'b0;
   logic [IW-1:0] cfg_blob = '0;
   logic [2:0] cfg_field = '0;
   logic [15:0] cfg_data = '0;
   logic commit = 1'b0;
   logic vblank = 1'b0;
   logic cfg_ack, cfg_err, pending, commit_done;
   logic [NB-1:0] sprite_enable;
   logic [NB-1:0][9:0] x1_pos, y1_pos, x2_pos, y2_pos;
   logic [NB-1:0][RW-1:0] ram_address;
   logic [NB-1:0][1:0] layer;
   logic [11:0] background;

   blob_cfg_ctrl #(.NR_OF_BLOBS(NB), .ram_add_width(RW)) dut (
      .clk(clk), .reset(reset),
      .cfg_req(cfg_req), .cfg_blob(cfg_blob), .cfg_field(cfg_field), .cfg_data(cfg_data),
      .cfg_ack(cfg_ack), .cfg_err(cfg_err),
      .commit(commit), .vblank(vblank), .pending(pending), .commit_done(commit_done),
      .sprite_enable(sprite_enable), .x1_pos(x1_pos), .y1_pos(y1_pos),
      .x2_pos(x2_pos), .y2_pos(y2_pos), .ram_address(ram_address),
      .layer(layer), .background(background)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int unsigned m_sh[7][NB];
   int unsigned m_act[7][NB];
   int unsigned m_bg_sh, m_bg_act;
   bit m_armed;

   function automatic int fw(input int f);
      case (f)
         0:          return 1;
         1, 2, 3, 4: return 10;
         5:          return RW;
         default:    return 2;
      endcase
   endfunction

   function automatic logic [63:0] exp_field(input int f);
      logic [63:0] v = '0;
      for (int b = 0; b < NB; b++)
         v |= 64'(m_act[f][b]) << (b * fw(f));
      return v;
   endfunction

   task automatic model_reset();
      for (int f = 0; f < 7; f++)
         for (int b = 0; b < NB; b++) begin
            m_sh[f][b]  = 0;
            m_act[f][b] = 0;
         end
      m_bg_sh  = 0;
      m_bg_act = 0;
      m_armed  = 0;
   endtask

   task automatic model_write(input int b, input int f, input logic [15:0] d);
      if (f == 7)
         m_bg_sh = d & 16'h0fff;
      else if (b < NB)
         m_sh[f][b] = d & ((1 << fw(f)) - 1);
   endtask

   task automatic model_load();
      for (int f = 0; f < 7; f++)
         for (int b = 0; b < NB; b++)
            m_act[f][b] = m_sh[f][b];
      m_bg_act = m_bg_sh;
      m_armed  = 0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " enable"}, 64'(sprite_enable), exp_field(0));
      chk({tag, " x1"}, 64'(x1_pos), exp_field(1));
      chk({tag, " y1"}, 64'(y1_pos), exp_field(2));
      chk({tag, " x2"}, 64'(x2_pos), exp_field(3));
      chk({tag, " y2"}, 64'(y2_pos), exp_field(4));
      chk({tag, " ram"}, 64'(ram_address), exp_field(5));
      chk({tag, " layer"}, 64'(layer), exp_field(6));
      chk({tag, " bg"}, 64'(background), 64'(m_bg_act));
      chk({tag, " pending"}, 64'(pending), 64'(m_armed));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int b, input int f, input logic [15:0] d);
      int n = 0;
      cfg_req   = 1'b1;
      cfg_blob  = b[IW-1:0];
      cfg_field = f[2:0];
      cfg_data  = d;
      do begin
         step();
         n++;
      end while (!cfg_ack && n < 400);
      cfg_req = 1'b0;
      chk("write ack", 64'(cfg_ack), 64'(1));
      chk("write err", 64'(cfg_err), 64'((f != 7 && b >= NB) ? 1 : 0));
      chk("write latency", 64'(n), 64'(1));
      model_write(b, f, d);
      step();
      chk("ack one pulse", 64'(cfg_ack), 64'(0));
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
      m_armed = 1;
      chk("commit pending", 64'(pending), 64'(1));
   endtask

   task automatic vblank_pulse(input string tag);
      bit exp_done;
      vblank = 1'b1;
      step();
      exp_done = m_armed;
      if (m_armed) model_load();
      check_all(tag);
      chk({tag, " done"}, 64'(commit_done), 64'(exp_done));
      step();
      chk({tag, " done end"}, 64'(commit_done), 64'(0));
      vblank = 1'b0;
      step();
   endtask

   initial begin
      int r;
      logic [15:0] d;
      model_reset();

      // Reset state
      repeat (3) step();
      check_all("reset");
      chk("reset ack", 64'(cfg_ack), 64'(0));
      chk("reset done", 64'(commit_done), 64'(0));
      reset = 1'b0;
      step();
      check_all("post reset");

      // Write then commit with a long wait before vblank
      do_write(2, 1, 16'd320);
      do_commit();
      for (int i = 0; i < 100; i++) begin
         step();
         chk("wait x1", 64'(x1_pos[2]), 64'(0));
         chk("wait pending", 64'(pending), 64'(1));
         chk("wait done", 64'(commit_done), 64'(0));
      end
      vblank_pulse("commit1");
      chk("x1[2] committed", 64'(x1_pos[2]), 64'(320));

      // Stall while armed
      do_commit();
      cfg_req = 1'b1; cfg_blob = '0; cfg_field = 3'd7; cfg_data = 16'h0F00;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall ack", 64'(cfg_ack), 64'(0));
      end
      vblank = 1'b1;
      step();
      model_load();
      check_all("stall edge");
      chk("stall edge ack", 64'(cfg_ack), 64'(0));
      chk("stall edge done", 64'(commit_done), 64'(1));
      step();
      cfg_req = 1'b0;
      chk("stall late ack", 64'(cfg_ack), 64'(1));
      chk("stall late done", 64'(commit_done), 64'(0));
      model_write(0, 7, 16'h0F00);
      check_all("stall bg held");
      vblank = 1'b0;
      step();
      chk("stall ack end", 64'(cfg_ack), 64'(0));
      do_commit();
      vblank_pulse("stall commit");
      chk("bg F00", 64'(background), 64'(12'hF00));

      // Invalid index
      do_write(3, 1, 16'($urandom));
      do_commit();
      vblank_pulse("invalid");

      // Commit coincident with vblank rise is not caught by that edge
      do_write(0, 3, 16'($urandom));
      commit = 1'b1; vblank = 1'b1;
      step();
      commit = 1'b0;
      m_armed = 1;
      check_all("coincident");
      chk("coincident done", 64'(commit_done), 64'(0));
      step(); step();
      check_all("coincident hold");
      vblank = 1'b0;
      step();
      vblank_pulse("coincident commit");

      // Write and commit in the same IDLE cycle, vblank edge in the ack cycle
      d = 16'($urandom);
      cfg_req = 1'b1; cfg_blob = 2'd1; cfg_field = 3'd5; cfg_data = d; commit = 1'b1;
      step();
      cfg_req = 1'b0; commit = 1'b0;
      chk("wrcommit ack", 64'(cfg_ack), 64'(1));
      chk("wrcommit err", 64'(cfg_err), 64'(0));
      model_write(1, 5, d);
      m_armed = 1;
      check_all("wrcommit");
      vblank_pulse("wrcommit edge");

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            do_commit();
            repeat (int'($urandom_range(0, 4))) step();
            vblank_pulse("rand commit");
         end else begin
            do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 16'($urandom));
            check_all("rand write");
         end
      end

      // Reset while armed
      do_write(1, 0, 16'h1);
      do_commit();
      vblank_pulse("pre reset");
      do_write(2, 6, 16'h3);
      do_commit();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset armed");
      chk("reset armed ack", 64'(cfg_ack), 64'(0));
      chk("reset armed done", 64'(commit_done), 64'(0));
      step(); step();
      reset = 1'b0;
      step();
      vblank_pulse("after reset");
      check_all("after reset final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
